ex_stage: RTL and testbench

Execute stage of the MIPS pipeline, directly downstream of the ID stage. Consumes the decoded instruction word, both register-file read values and the sign-extended immediate, and produces the ALU result for memory/write-back. Contains the HI/LO register pair and an iterative 32-cycle multiply/divide engine. While that engine runs, the block holds off upstream with `Busy`.

---
 rtl/ex_stage_pkg.sv | 40 ++++
 rtl/ex_stage_if.sv | 27 ++
 rtl/ex_stage_muldiv_seq.sv | 112 +++++++++++
 rtl/ex_stage.sv | 141 ++++++++++++++
 tb/tb_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: datapath width, MIPS op and funct codes.
// No logic; imported by the interface, the mul/div engine and the top.
// Names are prefixed OP_/FN_ to keep op and funct spaces visibly separate.
package ex_stage_pkg;

  localparam int XLEN = 32;

  // Primary opcodes, Ins[31:26]
  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-form function codes, Ins[5:0]
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/ex_stage_if.sv
// ID->EX instruction bus plus the EX result/status signals.
// No latency of its own; upstream (master) drives the instruction side.
// Busy is the hold-off back to upstream: while high, Valid is ignored.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic            Valid;
  logic [XLEN-1:0] Ins;
  logic [XLEN-1:0] Rdata1;
  logic [XLEN-1:0] Rdata2;
  logic [XLEN-1:0] Ed32;
  logic            Busy;
  logic [XLEN-1:0] Result;
  logic            Res_valid;
  logic            Ovf;
  logic            Ill;

  modport master (
    output Valid, Ins, Rdata1, Rdata2, Ed32,
    input  Busy, Result, Res_valid, Ovf, Ill
  );

  modport slave (
    input  Valid, Ins, Rdata1, Rdata2, Ed32,
    output Busy, Result, Res_valid, Ovf, Ill
  );
endinterface

// File: rtl/ex_stage_muldiv_seq.sv
// Iterative 32-step multiply / restoring divide on magnitudes, signs applied in FIX.
// Latency: start edge T, 32 steps, FIX cycle; done_o high in the cycle before the edge T+33.
// busy_o is high from T to T+33; start_i is only honoured in IDLE.
module muldiv_seq
  import ex_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            div_i,
  input  logic            sign_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q;     // multiplicand or divisor magnitude
  logic [31:0] dvd_q;      // raw dividend, returned as HI on divide by zero
  logic        is_div_q;
  logic        neg_lo_q;   // negate product / quotient
  logic        neg_hi_q;   // negate remainder (dividend was negative)
  logic        dz_q;

  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh, diff;
  logic [63:0] div_next;

  assign a_mag = (sign_i && a_i[31]) ? -a_i : a_i;
  assign b_mag = (sign_i && b_i[31]) ? -b_i : b_i;

  // One shift-add step: add multiplicand if the current multiplier bit is set, shift right.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // One restoring step: shift left, trial-subtract, keep the difference if no borrow.
  assign rem_sh   = acc_q[63:31];
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign div_next = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                             : {diff[31:0],   acc_q[30:0], 1'b1};

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_FIX);

  // Engine state: latch magnitudes on start, iterate 32 times, then one FIX cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q    <= '0;
            opnd_q   <= div_i ? b_mag : a_mag;
            acc_q    <= {32'd0, (div_i ? a_mag : b_mag)};
            dvd_q    <= a_i;
            is_div_q <= div_i;
            dz_q     <= div_i && (b_i == '0);
            neg_lo_q <= sign_i && (a_i[31] ^ b_i[31]);
            neg_hi_q <= div_i && sign_i && a_i[31];
            state_q  <= div_i ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_FIX;
        end
        S_FIX:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sign fix-up of the finished magnitudes; only meaningful while done_o is high.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!is_div_q) begin
      {hi_o, lo_o} = neg_lo_q ? -acc_q : acc_q;
    end else if (dz_q) begin
      hi_o = dvd_q;
      lo_o = 32'hFFFF_FFFF;
    end else begin
      hi_o = neg_hi_q ? -acc_q[63:32] : acc_q[63:32];
      lo_o = neg_lo_q ? -acc_q[31:0]  : acc_q[31:0];
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: decode, single-cycle ALU, HI/LO pair, iterative mul/div.
// Latency: ALU result registered one cycle after accept; mul/div writes HI/LO 33 cycles after accept.
// Holds off upstream with Busy while mul/div runs; Valid during Busy is ignored.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  ex_stage_if.slave  bus
);

  logic [5:0]  op, funct;
  logic [4:0]  shamt;
  logic [31:0] a, b, ed, zimm;
  logic [31:0] sum_ab, sum_ai, diff_ab;

  logic [31:0] alu_d;
  logic        ovf_d, ill_d;
  logic        is_md, md_div, md_sign;

  logic [31:0] result_q, hi_q, lo_q;
  logic        res_valid_q, ovf_q, ill_q;

  logic        accept;
  logic        md_busy, md_done;
  logic [31:0] md_hi, md_lo;
  logic        unused_ins;

  assign op      = bus.Ins[31:26];
  assign funct   = bus.Ins[5:0];
  assign shamt   = bus.Ins[10:6];
  assign a       = bus.Rdata1;
  assign b       = bus.Rdata2;
  assign ed      = bus.Ed32;
  assign zimm    = {16'h0, bus.Ins[15:0]};
  assign unused_ins = ^bus.Ins[25:16];

  assign sum_ab  = a + b;
  assign sum_ai  = a + ed;
  assign diff_ab = a - b;

  assign accept  = bus.Valid && !md_busy;

  // Decode and ALU; mul/div instructions only raise is_md and produce no result.
  always_comb begin
    alu_d   = '0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    is_md   = 1'b0;
    md_div  = 1'b0;
    md_sign = 1'b0;
    case (op)
      OP_R_FORM: begin
        case (funct)
          FN_ADD: begin
            alu_d = sum_ab;
            ovf_d = (a[31] == b[31]) && (sum_ab[31] != a[31]);
          end
          FN_ADDU: alu_d = sum_ab;
          FN_SUB: begin
            alu_d = diff_ab;
            ovf_d = (a[31] != b[31]) && (diff_ab[31] != a[31]);
          end
          FN_SUBU:  alu_d = diff_ab;
          FN_AND:   alu_d = a & b;
          FN_OR:    alu_d = a | b;
          FN_XOR:   alu_d = a ^ b;
          FN_NOR:   alu_d = ~(a | b);
          FN_SLT:   alu_d = {31'd0, ($signed(a) < $signed(b))};
          FN_SLTU:  alu_d = {31'd0, (a < b)};
          FN_SLL:   alu_d = b << shamt;
          FN_SRL:   alu_d = b >> shamt;
          FN_SRA:   alu_d = $unsigned($signed(b) >>> shamt);
          FN_MFHI:  alu_d = hi_q;
          FN_MFLO:  alu_d = lo_q;
          FN_MULT:  begin is_md = 1'b1; md_sign = 1'b1; end
          FN_MULTU: is_md = 1'b1;
          FN_DIV:   begin is_md = 1'b1; md_div = 1'b1; md_sign = 1'b1; end
          FN_DIVU:  begin is_md = 1'b1; md_div = 1'b1; end
          default:  ill_d = 1'b1;
        endcase
      end
      OP_ADDI: begin
        alu_d = sum_ai;
        ovf_d = (a[31] == ed[31]) && (sum_ai[31] != a[31]);
      end
      OP_ADDIU: alu_d = sum_ai;
      OP_SLTI:  alu_d = {31'd0, ($signed(a) < $signed(ed))};
      OP_ANDI:  alu_d = a & zimm;
      OP_ORI:   alu_d = a | zimm;
      OP_LUI:   alu_d = {bus.Ins[15:0], 16'h0};
      OP_LW:    alu_d = sum_ai;
      OP_SW:    alu_d = sum_ai;
      default:  ill_d = 1'b1;
    endcase
  end

  muldiv_seq u_muldiv (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (accept && is_md),
    .div_i   (md_div),
    .sign_i  (md_sign),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  // Output registers and HI/LO; HI/LO only change on the engine's FIX->IDLE edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q    <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      res_valid_q <= accept && !is_md;
      if (accept && !is_md) begin
        result_q <= alu_d;
        ovf_q    <= ovf_d;
        ill_q    <= ill_d;
      end
      if (md_done) begin
        hi_q <= md_hi;
        lo_q <= md_lo;
      end
    end
  end

  assign bus.Busy      = md_busy;
  assign bus.Result    = result_q;
  assign bus.Res_valid = res_valid_q;
  assign bus.Ovf       = ovf_q;
  assign bus.Ill       = ill_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, multi-cycle mul/div and reset
// sequences, then randomized ALU and mul/div traffic against an arithmetic reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ex_stage_if bus ();

  ex_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } vec_t;

  vec_t vt [22];

  logic [5:0] fn_list [16] = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                               FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_MFHI, FN_MFLO, 6'h3F};
  logic [5:0] op_list [9]  = '{OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, 6'h3E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'd10, 5'd11, 5'd9, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd10, 5'd11, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    bus.Valid  = 1'b1;
    bus.Ins    = ins;
    bus.Rdata1 = r1;
    bus.Rdata2 = r2;
    bus.Ed32   = {{16{ins[15]}}, ins[15:0]};
  endtask

  // Reference ALU from the instruction-set rules, using wide signed arithmetic.
  function automatic void model_alu(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                                    output logic [31:0] res, output logic ovf, output logic ill);
    longint sa, sb, si, s;
    logic [31:0] ed, zi;
    int sh;
    sa = $signed(r1);
    sb = $signed(r2);
    ed = {{16{ins[15]}}, ins[15:0]};
    si = $signed(ed);
    zi = {16'h0, ins[15:0]};
    sh = int'(ins[10:6]);
    res = 32'd0; ovf = 1'b0; ill = 1'b0; s = 0;
    if (ins[31:26] == OP_R_FORM) begin
      case (ins[5:0])
        FN_ADD:  begin s = sa + sb; res = 32'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        FN_ADDU: res = 32'(sa + sb);
        FN_SUB:  begin s = sa - sb; res = 32'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        FN_SUBU: res = 32'(sa - sb);
        FN_AND:  res = r1 & r2;
        FN_OR:   res = r1 | r2;
        FN_XOR:  res = r1 ^ r2;
        FN_NOR:  res = ~(r1 | r2);
        FN_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
        FN_SLTU: res = (r1 < r2) ? 32'd1 : 32'd0;
        FN_SLL:  res = 32'(longint'({32'd0, r2}) * (64'sd1 <<< sh));
        FN_SRL:  res = 32'(longint'({32'd0, r2}) / (64'sd1 <<< sh));
        FN_SRA:  res = 32'(sb >>> sh);
        FN_MFHI: res = m_hi;
        FN_MFLO: res = m_lo;
        default: ill = 1'b1;
      endcase
    end else begin
      case (ins[31:26])
        OP_ADDI:  begin s = sa + si; res = 32'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
        OP_ADDIU: res = 32'(sa + si);
        OP_SLTI:  res = (sa < si) ? 32'd1 : 32'd0;
        OP_ANDI:  res = r1 & zi;
        OP_ORI:   res = r1 | zi;
        OP_LUI:   res = {ins[15:0], 16'h0};
        OP_LW, OP_SW: res = 32'(sa + si);
        default:  ill = 1'b1;
      endcase
    end
  endfunction

  // Reference HI/LO update for multiply/divide.
  function automatic void model_md(input logic [5:0] fn, input logic [31:0] r1, input logic [31:0] r2);
    longint a, b, q, r;
    logic [63:0] p;
    case (fn)
      FN_MULT: begin
        a = $signed(r1); b = $signed(r2); p = 64'(a * b);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      FN_MULTU: begin
        p = {32'd0, r1} * {32'd0, r2};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      default: begin
        if (fn == FN_DIV) begin a = $signed(r1); b = $signed(r2); end
        else begin a = longint'({32'd0, r1}); b = longint'({32'd0, r2}); end
        if (r2 == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = r1;
        end else begin
          q = a / b; r = a % b;
          m_lo = 32'(q); m_hi = 32'(r);
        end
      end
    endcase
  endfunction

  // Issue one ALU instruction at a falling edge and check the registered result one cycle later.
  task automatic step_alu(input string name, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] er, input logic eo, input logic ei);
    drive(ins, r1, r2);
    @(negedge CLK);
    bus.Valid = 1'b0;
    chk({name, "_rv"},  32'(bus.Res_valid), 32'd1);
    chk({name, "_res"}, bus.Result, er);
    chk({name, "_ovf"}, 32'(bus.Ovf), 32'(eo));
    chk({name, "_ill"}, 32'(bus.Ill), 32'(ei));
  endtask

  // Issue a mul/div, count Busy cycles while pulsing Valid with ADDs that must be ignored.
  task automatic md_run(input string name, input logic [5:0] fn, input logic [31:0] r1, input logic [31:0] r2);
    int n;
    logic rv_seen;
    drive(mk_r(fn, 5'd0), r1, r2);
    model_md(fn, r1, r2);
    @(negedge CLK);
    bus.Valid = 1'b0;
    n = 0;
    rv_seen = 1'b0;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      if (bus.Res_valid !== 1'b0) rv_seen = 1'b1;
      if ($urandom_range(0, 1) == 1) drive(mk_r(FN_ADD, 5'd0), $urandom, $urandom);
      else bus.Valid = 1'b0;
      @(negedge CLK);
    end
    bus.Valid = 1'b0;
    chk({name, "_busy_cycles"}, 32'(n), 32'd33);
    chk({name, "_ignored"}, 32'(rv_seen | bus.Res_valid), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, r1, r2, er;
    logic eo, ei;
    int sel;
    logic [5:0] fn;

    vt[0]  = '{mk_r(FN_ADD, 5'd0),  32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vt[1]  = '{mk_r(FN_ADD, 5'd0),  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1, 1'b0};
    vt[2]  = '{mk_r(FN_ADDU, 5'd0), 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0};
    vt[3]  = '{mk_r(FN_SUB, 5'd0),  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b0};
    vt[4]  = '{mk_r(FN_SUBU, 5'd0), 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0};
    vt[5]  = '{mk_i(OP_SLTI, 16'hFFFF), 32'hFFFFFFFE, 32'd0,    32'd1,        1'b0, 1'b0};
    vt[6]  = '{mk_i(OP_ANDI, 16'hFFFF), 32'h12345678, 32'd0,    32'h00005678, 1'b0, 1'b0};
    vt[7]  = '{mk_r(6'h3F, 5'd0),   32'h11111111, 32'h22222222, 32'd0,        1'b0, 1'b1};
    vt[8]  = '{mk_i(OP_LUI, 16'hABCD),  32'h55555555, 32'd0,    32'hABCD0000, 1'b0, 1'b0};
    vt[9]  = '{mk_r(FN_SRA, 5'd4),  32'd0,        32'h80000000, 32'hF8000000, 1'b0, 1'b0};
    vt[10] = '{mk_r(FN_SLTU, 5'd0), 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0};
    vt[11] = '{mk_r(FN_SLT, 5'd0),  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0};
    vt[12] = '{mk_i(OP_LW, 16'hFFFC),   32'h00001000, 32'd0,    32'h00000FFC, 1'b0, 1'b0};
    vt[13] = '{mk_r(FN_NOR, 5'd0),  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
    vt[14] = '{mk_i(OP_ADDI, 16'h0001), 32'h7FFFFFFF, 32'd0,    32'h80000000, 1'b1, 1'b0};
    vt[15] = '{mk_r(FN_MFHI, 5'd0), 32'd3,        32'd4,        32'd0,        1'b0, 1'b0};
    vt[16] = '{mk_i(OP_ORI, 16'h8001),  32'hF0000000, 32'd0,    32'hF0008001, 1'b0, 1'b0};
    vt[17] = '{mk_i(6'h3E, 16'h1234),   32'h00000001, 32'd2,    32'd0,        1'b0, 1'b1};
    vt[18] = '{mk_r(FN_SRL, 5'd4),  32'd0,        32'h80000000, 32'h08000000, 1'b0, 1'b0};
    vt[19] = '{mk_r(FN_SLL, 5'd31), 32'd0,        32'd3,        32'h80000000, 1'b0, 1'b0};
    vt[20] = '{mk_i(OP_SW, 16'h0004),   32'h00000010, 32'd0,    32'h00000014, 1'b0, 1'b0};
    vt[21] = '{mk_r(FN_XOR, 5'd0),  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0};

    RST = 1'b1;
    bus.Valid = 1'b0; bus.Ins = '0; bus.Rdata1 = '0; bus.Rdata2 = '0; bus.Ed32 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_rv",   32'(bus.Res_valid), 32'd0);
    chk("rst_res",  bus.Result, 32'd0);
    chk("rst_ovf",  32'(bus.Ovf), 32'd0);
    chk("rst_ill",  32'(bus.Ill), 32'd0);
    RST = 1'b0;

    // Directed vectors, issued back to back
    for (int i = 0; i < 22; i++)
      step_alu($sformatf("vec%0d", i), vt[i].ins, vt[i].r1, vt[i].r2, vt[i].res, vt[i].ovf, vt[i].ill);
    @(negedge CLK);
    chk("idle_rv", 32'(bus.Res_valid), 32'd0);

    // MULT -3 x 5
    md_run("mult", FN_MULT, 32'hFFFFFFFD, 32'd5);
    step_alu("mult_lo", mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, 32'hFFFFFFF1, 1'b0, 1'b0);
    step_alu("mult_hi", mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);

    // DIV -7 / 2
    md_run("div", FN_DIV, 32'hFFFFFFF9, 32'd2);
    step_alu("div_lo", mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, 32'hFFFFFFFD, 1'b0, 1'b0);
    step_alu("div_hi", mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);

    // DIVU 7 / 0
    md_run("divz", FN_DIVU, 32'd7, 32'd0);
    step_alu("divz_lo", mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    step_alu("divz_hi", mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, 32'd7, 1'b0, 1'b0);

    // DIV 0x80000000 / -1
    md_run("divov", FN_DIV, 32'h80000000, 32'hFFFFFFFF);
    step_alu("divov_lo", mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, 32'h80000000, 1'b0, 1'b0);
    step_alu("divov_hi", mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset in cycle 10 of a DIVU aborts it and clears HI/LO
    drive(mk_r(FN_DIVU, 5'd0), 32'd100, 32'd7);
    @(negedge CLK);
    bus.Valid = 1'b0;
    repeat (9) @(negedge CLK);
    chk("abort_busy_before", 32'(bus.Busy), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    step_alu("abort_hi", mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step_alu("abort_lo", mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset together with Valid: nothing accepted
    RST = 1'b1;
    drive(mk_r(FN_ADD, 5'd0), 32'd1, 32'd2);
    @(negedge CLK);
    RST = 1'b0;
    bus.Valid = 1'b0;
    chk("rstvalid_rv",  32'(bus.Res_valid), 32'd0);
    chk("rstvalid_res", bus.Result, 32'd0);

    // Randomized ALU traffic
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 24);
      if (sel < 16) ins = {6'h00, 20'($urandom), fn_list[sel]};
      else          ins = {op_list[sel - 16], 26'($urandom)};
      r1 = pick();
      r2 = pick();
      model_alu(ins, r1, r2, er, eo, ei);
      step_alu("rand_alu", ins, r1, r2, er, eo, ei);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        chk("rand_gap_rv", 32'(bus.Res_valid), 32'd0);
      end
    end

    // Randomized mul/div traffic
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 3))
        0: fn = FN_MULT;
        1: fn = FN_MULTU;
        2: fn = FN_DIV;
        default: fn = FN_DIVU;
      endcase
      r1 = pick();
      r2 = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      md_run("rand_md", fn, r1, r2);
      model_alu(mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, er, eo, ei);
      step_alu("rand_md_hi", mk_r(FN_MFHI, 5'd0), 32'd0, 32'd0, er, eo, ei);
      model_alu(mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, er, eo, ei);
      step_alu("rand_md_lo", mk_r(FN_MFLO, 5'd0), 32'd0, 32'd0, er, eo, ei);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
